axi_rd_burst_master: RTL and testbench

AXI4 read-burst initiator for cnn_accel_top. It fetches image tiles and conv weights from the 128-bit memory port. A descriptor (start address, beat count) is split into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary. Read beats are delivered on a valid/ready stream through a 2-entry buffer, with last and done/error signalling.

---
 rtl/axi_rd_burst_master_if.sv | 44 ++++
 rtl/axi_rd_burst_master.sv | 180 ++++++++++++++++++
 tb/tb_axi_rd_burst_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_burst_master_if.sv
// Signal bundle for axi_rd_burst_master: descriptor input, beat stream output and
// the AXI4 AR/R channels towards memory.
interface axi_rd_burst_master_if #(
  parameter int unsigned BEATS_W = 16
) ();
  logic               desc_valid;
  logic               desc_ready;
  logic [47:0]        desc_addr;
  logic [BEATS_W-1:0] desc_beats;

  logic               rd_valid;
  logic               rd_ready;
  logic [127:0]       rd_data;
  logic               rd_last;
  logic               done;
  logic               done_err;

  logic [47:0]        m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;
  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [127:0]       m_axi_rdata;
  logic               m_axi_rlast;
  logic               m_axi_rvalid;
  logic               m_axi_rready;

  modport master (
    input  desc_valid, desc_addr, desc_beats, rd_ready,
    input  m_axi_arready, m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    output desc_ready, rd_valid, rd_data, rd_last, done, done_err,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_rready
  );

  modport slave (
    output desc_valid, desc_addr, desc_beats, rd_ready,
    output m_axi_arready, m_axi_rdata, m_axi_rlast, m_axi_rvalid,
    input  desc_ready, rd_valid, rd_data, rd_last, done, done_err,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_rd_burst_master.sv
// AXI4 read-burst initiator: splits (addr, beats) descriptors into 4KB-safe INCR bursts
// and streams the returned beats through a 2-entry output buffer.
module axi_rd_burst_master #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BEATS_W   = 16
) (
  input logic                   clk,
  input logic                   rst_b,
  axi_rd_burst_master_if.master bus
);

  localparam int unsigned CW = (BEATS_W > 9) ? BEATS_W : 9;

  typedef enum logic [1:0] {StIdle, StAr, StR, StDrain} state_e;

  state_e             r_state;
  logic [47:0]        r_addr;
  logic [BEATS_W-1:0] r_remaining;
  logic [8:0]         r_burst;
  logic [8:0]         r_beat_cnt;
  logic               r_err;
  logic               r_done;
  logic               r_done_err;
  logic               r_desc_ready;
  logic               r_arvalid;
  logic [47:0]        r_araddr;
  logic [7:0]         r_arlen;

  logic [127:0]       r_buf_data [2];
  logic [1:0]         r_buf_last;
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;

  logic [47:0]        w_desc_addr;
  logic [8:0]         w_burst_idle;
  logic [8:0]         w_burst_next;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_pop;
  logic               w_last_in;
  logic               w_rready;

  // Beats for the next burst: limited by what is left, MAX_BURST and the 4KB page end.
  function automatic logic [8:0] burst_of(input logic [7:0] line,
                                          input logic [BEATS_W-1:0] rem);
    logic [CW-1:0] lim;
    logic [CW-1:0] room;
    logic [CW-1:0] left;
    room = CW'(9'd256 - {1'b0, line});
    lim  = CW'(MAX_BURST);
    left = CW'(rem);
    if (room < lim) lim = room;
    if (left < lim) lim = left;
    return 9'(lim);
  endfunction

  assign w_desc_addr  = bus.desc_addr & ~48'hF;
  assign w_burst_idle = burst_of(w_desc_addr[11:4], bus.desc_beats);
  assign w_burst_next = burst_of(r_addr[11:4], r_remaining);
  assign w_ar_hs      = r_arvalid & bus.m_axi_arready;
  assign w_rready     = (r_state == StR) && (r_count != 2'd2);
  assign w_r_hs       = bus.m_axi_rvalid & w_rready;
  assign w_pop        = (r_count != 2'd0) & bus.rd_ready;
  assign w_last_in    = (r_beat_cnt == 9'd1) && (r_remaining == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_done_err   <= 1'b0;
      r_desc_ready <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.desc_valid && r_desc_ready) begin
            r_err <= 1'b0;
            if (bus.desc_beats == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr       <= w_desc_addr;
              r_remaining  <= bus.desc_beats;
              r_burst      <= w_burst_idle;
              r_araddr     <= w_desc_addr;
              r_arlen      <= 8'(w_burst_idle - 9'd1);
              r_arvalid    <= 1'b1;
              r_desc_ready <= 1'b0;
              r_state      <= StAr;
            end
          end else begin
            r_desc_ready <= 1'b1;
          end
        end
        StAr: begin
          if (w_ar_hs) begin
            r_arvalid   <= 1'b0;
            r_beat_cnt  <= r_burst;
            r_addr      <= r_addr + {35'd0, r_burst, 4'h0};
            r_remaining <= r_remaining - BEATS_W'(r_burst);
            r_state     <= StR;
          end
        end
        StR: begin
          if (w_r_hs) begin
            // rlast is only audited; the local beat count decides where a burst ends.
            if (bus.m_axi_rlast != (r_beat_cnt == 9'd1)) r_err <= 1'b1;
            r_beat_cnt <= r_beat_cnt - 9'd1;
            if (r_beat_cnt == 9'd1) begin
              if (r_remaining != '0) begin
                r_burst   <= w_burst_next;
                r_araddr  <= r_addr;
                r_arlen   <= 8'(w_burst_next - 9'd1);
                r_arvalid <= 1'b1;
                r_state   <= StAr;
              end else begin
                r_state <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if (w_pop && r_buf_last[r_rptr]) begin
            r_done       <= 1'b1;
            r_done_err   <= r_err;
            r_desc_ready <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_r_hs) begin
        r_buf_data[r_wptr] <= bus.m_axi_rdata;
        r_buf_last[r_wptr] <= w_last_in;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_r_hs && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_r_hs && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign bus.desc_ready    = r_desc_ready;
  assign bus.rd_valid      = (r_count != 2'd0);
  assign bus.rd_data       = r_buf_data[r_rptr];
  assign bus.rd_last       = r_buf_last[r_rptr];
  assign bus.done          = r_done;
  assign bus.done_err      = r_done_err;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arlen   = r_arlen;
  assign bus.m_axi_arsize  = 3'd4;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = w_rready;

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Bench for axi_rd_burst_master: memory/slave model, stream consumer, descriptor table,
// reset-mid-burst sequence and randomized descriptors checked against a burst-split model.
module tb_axi_rd_burst_master;

  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst_b;
  int   cyc = 0;
  int   n_chk;
  int   n_fail;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_rd_burst_master_if #(.BEATS_W(16)) bus ();

  axi_rd_burst_master #(
    .MAX_BURST(MAX_BURST),
    .BEATS_W  (16)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  typedef struct {
    logic [47:0] addr;
    int          len;
  } ar_t;

  typedef struct {
    logic [47:0] addr;
    int          beats;
    int          mode;     // rd_ready: 0 random, 1 always, 2 toggle
    bit          inj;      // slave raises rlast on the third beat instead of the last
    int          par;
    int          prv;
    int          exp_nar;
    bit          exp_err;
    bit          lat;
  } vec_t;

  int   k_mode;
  int   k_par;
  int   k_prv;
  bit   k_inj;

  ar_t          ar_pend[$];
  ar_t          ar_log[$];
  ar_t          exp_ar[$];
  logic [127:0] bl_data[$];
  bit           bl_last[$];
  int           done_cnt;
  int           done_cyc;
  int           last_pop_cyc;
  bit           done_err_seen;
  int           tb_cnt;

  function automatic logic [127:0] mem_word(input logic [47:0] idx);
    logic [31:0] w;
    w = idx[31:0] ^ {16'd0, idx[47:32]};
    return {w ^ 32'hDEAD_BEEF, w * 32'd7 + 32'h0101, ~w, w + 32'h1234_0000};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: walk the descriptor, cutting at MAX_BURST and at each 4KB page end.
  task automatic model_ars(input logic [47:0] a, input int nb);
    logic [47:0] aa;
    int rem;
    int room;
    int b;
    aa  = a & ~48'hF;
    rem = nb;
    exp_ar.delete();
    while (rem > 0) begin
      room = (4096 - int'(aa % 48'd4096)) / 16;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      exp_ar.push_back('{aa, b - 1});
      aa  = aa + 48'(b * 16);
      rem = rem - b;
    end
  endtask

  task automatic clear_logs();
    ar_log.delete();
    bl_data.delete();
    bl_last.delete();
    done_cnt      = 0;
    done_cyc      = 0;
    last_pop_cyc  = -1;
    done_err_seen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, bus.desc_ready, 0);
    check({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
    check({tag, "_araddr"}, bus.m_axi_araddr, 0);
    check({tag, "_arlen"}, bus.m_axi_arlen, 0);
    check({tag, "_arsize"}, bus.m_axi_arsize, 4);
    check({tag, "_arburst"}, bus.m_axi_arburst, 1);
    check({tag, "_rready"}, bus.m_axi_rready, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
    check({tag, "_rd_last"}, bus.rd_last, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_done_err"}, bus.done_err, 0);
  endtask

  // Slave, consumer and monitor: sample on the falling edge, drive 1 time unit after rising.
  initial begin
    bit           ar_hs;
    bit           r_hs;
    bit           pop;
    bit           ar_wait;
    logic [47:0]  ar_wait_addr;
    logic [7:0]   ar_wait_len;
    bit           rd_wait;
    logic [127:0] rd_wait_data;
    bit           rd_wait_last;
    int           r_idx;
    ar_hs = 0; r_hs = 0; pop = 0; ar_wait = 0; rd_wait = 0; r_idx = 0; tb_cnt = 0;
    ar_wait_addr = '0; ar_wait_len = '0; rd_wait_data = '0; rd_wait_last = 0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rlast   = 1'b0;
    bus.rd_ready      = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = 0; r_hs = 0; pop = 0;
      if (!rst_b) begin
        ar_pend.delete(); r_idx = 0; tb_cnt = 0; ar_wait = 0; rd_wait = 0;
      end else begin
        ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
        pop   = bus.rd_valid && bus.rd_ready;
        if (ar_wait) begin
          check("ar_hold_valid", bus.m_axi_arvalid, 1);
          check("ar_hold_addr", bus.m_axi_araddr, ar_wait_addr);
          check("ar_hold_len", bus.m_axi_arlen, ar_wait_len);
        end
        if (bus.m_axi_arvalid) begin
          check("arsize", bus.m_axi_arsize, 4);
          check("arburst", bus.m_axi_arburst, 1);
          check("ar_one_outstanding", 128'(ar_pend.size()), 0);
        end
        if (rd_wait) begin
          check("rd_hold_valid", bus.rd_valid, 1);
          check("rd_hold_data", bus.rd_data, rd_wait_data);
          check("rd_hold_last", bus.rd_last, rd_wait_last);
        end
        check("rd_valid_vs_fill", bus.rd_valid, tb_cnt != 0);
        if (tb_cnt == 2) check("rready_when_full", bus.m_axi_rready, 0);
        if (ar_hs) ar_log.push_back('{bus.m_axi_araddr, int'(bus.m_axi_arlen)});
        if (pop) begin
          bl_data.push_back(bus.rd_data);
          bl_last.push_back(bus.rd_last);
          if (bus.rd_last) last_pop_cyc = cyc;
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc      = cyc;
          done_err_seen = bus.done_err;
        end
        tb_cnt = tb_cnt + int'(r_hs) - int'(pop);
        ar_wait      = bus.m_axi_arvalid && !bus.m_axi_arready;
        ar_wait_addr = bus.m_axi_araddr;
        ar_wait_len  = bus.m_axi_arlen;
        rd_wait      = bus.rd_valid && !bus.rd_ready;
        rd_wait_data = bus.rd_data;
        rd_wait_last = bus.rd_last;
      end
      @(posedge clk);
      #1;
      if (!rst_b) begin
        ar_pend.delete(); r_idx = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rlast   = 1'b0;
      end else begin
        if (ar_hs) ar_pend.push_back(ar_log[$]);
        if (r_hs && ar_pend.size() > 0) begin
          r_idx++;
          if (r_idx > ar_pend[0].len) begin
            void'(ar_pend.pop_front());
            r_idx = 0;
          end
        end
        bus.m_axi_arready = ($urandom % 100) < k_par;
        if (!(bus.m_axi_rvalid && !r_hs && ar_pend.size() > 0)) begin
          bus.m_axi_rvalid = (ar_pend.size() > 0) && (($urandom % 100) < k_prv);
        end
        if (bus.m_axi_rvalid) begin
          bus.m_axi_rdata = mem_word((ar_pend[0].addr >> 4) + 48'(r_idx));
          bus.m_axi_rlast = k_inj ? (r_idx == 2) : (r_idx == ar_pend[0].len);
        end else begin
          bus.m_axi_rdata = '0;
          bus.m_axi_rlast = 1'b0;
        end
      end
      case (k_mode)
        1:       bus.rd_ready = 1'b1;
        2:       bus.rd_ready = ~bus.rd_ready;
        default: bus.rd_ready = 1'($urandom % 2);
      endcase
    end
  end

  task automatic send_desc(input logic [47:0] a, input int nb, output int acc, output bit ok);
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b1;
    bus.desc_addr  = a;
    bus.desc_beats = 16'(nb);
    ok  = 0;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.desc_ready) begin
        acc = cyc;
        ok  = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = 48'($urandom);
    bus.desc_beats = '1;
    check("desc_accept", ok, 1);
  endtask

  task automatic run_desc(input string tag, input logic [47:0] a, input int nb, input int mode,
                          input bit inj, input int par, input int prv, input int exp_nar,
                          input bit exp_err, input bit lat);
    int acc;
    bit ok;
    int nar;
    int n;
    logic [47:0] base;
    k_mode = mode; k_inj = inj; k_par = par; k_prv = prv;
    model_ars(a, nb);
    nar = exp_ar.size();
    clear_logs();
    send_desc(a, nb, acc, ok);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, ok, 1);
    if (!ok) return;
    repeat (3) @(posedge clk);
    check({tag, "_n_ar"}, 128'(ar_log.size()), 128'(nar));
    if (exp_nar >= 0) check({tag, "_n_ar_tbl"}, 128'(ar_log.size()), 128'(exp_nar));
    n = (ar_log.size() < nar) ? ar_log.size() : nar;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_araddr%0d", tag, i), ar_log[i].addr, exp_ar[i].addr);
      check($sformatf("%s_arlen%0d", tag, i), 128'(ar_log[i].len), 128'(exp_ar[i].len));
    end
    check({tag, "_n_beats"}, 128'(bl_data.size()), 128'(nb));
    base = (a & ~48'hF) >> 4;
    n = (bl_data.size() < nb) ? bl_data.size() : nb;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), bl_data[i], mem_word(base + 48'(i)));
      check($sformatf("%s_last%0d", tag, i), bl_last[i], i == nb - 1);
    end
    check({tag, "_done_once"}, 128'(done_cnt), 1);
    check({tag, "_done_err"}, done_err_seen, exp_err);
    if (nb == 0) begin
      check({tag, "_zero_lat"}, 128'(done_cyc - acc), 1);
    end else begin
      check({tag, "_done_after_pop"}, 128'(done_cyc - last_pop_cyc), 1);
      if (lat) check({tag, "_latency"}, 128'(done_cyc - acc), 128'(nb + nar + 2));
    end
    k_inj = 0;
  endtask

  vec_t vecs[8];

  initial begin
    int acc;
    bit ok;
    n_chk = 0;
    n_fail = 0;
    rst_b = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_beats = '0;
    k_mode = 1; k_par = 100; k_prv = 100; k_inj = 0;
    clear_logs();

    //          addr        beats mode inj par  prv  nar err lat
    vecs[0] = '{48'h0,      0,    1,   0,  100, 100, 0,  0,  1};
    vecs[1] = '{48'h0,      40,   1,   0,  100, 100, 3,  0,  1};
    vecs[2] = '{48'hFC0,    8,    1,   0,  100, 100, 2,  0,  1};
    vecs[3] = '{48'h100,    16,   2,   0,  100, 100, 1,  0,  0};
    vecs[4] = '{48'h200,    4,    1,   1,  100, 100, 1,  1,  0};
    vecs[5] = '{48'h7,      1,    1,   0,  100, 100, 1,  0,  1};
    vecs[6] = '{48'hFF0,    3,    0,   0,  60,  70,  2,  0,  0};
    vecs[7] = '{48'h1000,   300,  1,   0,  100, 100, 19, 0,  1};

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      run_desc($sformatf("vec%0d", i), vecs[i].addr, vecs[i].beats, vecs[i].mode, vecs[i].inj,
               vecs[i].par, vecs[i].prv, vecs[i].exp_nar, vecs[i].exp_err, vecs[i].lat);
    end

    // Reset in the middle of a 16-beat burst, then a fresh descriptor.
    k_mode = 1; k_par = 100; k_prv = 100; k_inj = 0;
    clear_logs();
    send_desc(48'h0, 16, acc, ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bl_data.size() >= 5) begin
        ok = 1;
        break;
      end
    end
    check("rst_mid_progress", ok, 1);
    #3;
    rst_b = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    run_desc("rst_new", 48'h400, 2, 1, 0, 100, 100, 1, 0, 1);

    for (int t = 0; t < 14; t++) begin
      logic [47:0] a;
      int nb;
      a  = 48'($urandom_range(0, 32'h3FFF));
      nb = $urandom_range(0, 70);
      run_desc($sformatf("rnd%0d", t), a, nb, $urandom_range(0, 2), 0,
               $urandom_range(30, 100), $urandom_range(30, 100), -1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
